// File: rtl/traceback_dir_reader_if.sv
// Bundle between the traceback engine (master) and the direction-matrix reader (slave):
// row writes during scoring, start/feedback and the returned {last, dir} packets.
interface traceback_dir_reader_if #(
    parameter int unsigned SEQ_LENGTH       = 32,
    parameter int unsigned SEQ_LENGTH_W     = 5,
    parameter int unsigned DIR_W            = 2,
    parameter int unsigned DATA_PACKET_SIZE = 3
);
    logic                              wr_en;
    logic [SEQ_LENGTH_W-1:0]           wr_row;
    logic [SEQ_LENGTH*(DIR_W+1)-1:0]   wr_cells;
    logic                              wr_ready;
    logic                              start_of_traceback;
    logic                              en_traceback;
    logic [SEQ_LENGTH_W-1:0]           max_row;
    logic [SEQ_LENGTH_W-1:0]           max_col;
    logic [SEQ_LENGTH_W-1:0]           next_row;
    logic [SEQ_LENGTH_W-1:0]           next_col;
    logic [DATA_PACKET_SIZE-1:0]       data_packet;
    logic                              packet_valid;
    logic                              busy;
    logic                              dir_err;

    modport master (
        output wr_en, wr_row, wr_cells, start_of_traceback, en_traceback,
               max_row, max_col, next_row, next_col,
        input  wr_ready, data_packet, packet_valid, busy, dir_err
    );

    modport slave (
        input  wr_en, wr_row, wr_cells, start_of_traceback, en_traceback,
               max_row, max_col, next_row, next_col,
        output wr_ready, data_packet, packet_valid, busy, dir_err
    );
endinterface

// File: rtl/traceback_dir_reader.sv
// Direction-matrix store for the traceback engine: captures rows while scoring, then
// streams one registered {last, dir} packet per enabled cycle until the path start is hit.
module traceback_dir_reader #(
    parameter int unsigned SEQ_LENGTH       = 32,
    parameter int unsigned SEQ_LENGTH_W     = 5,
    parameter int unsigned DIR_W            = 2,
    parameter int unsigned DATA_PACKET_SIZE = 3
) (
    input logic                  clk,
    input logic                  rst,
    traceback_dir_reader_if.slave bus
);

    localparam int unsigned CellW = DIR_W + 1;
    localparam int unsigned StepW = SEQ_LENGTH_W + 1;
    localparam logic [StepW-1:0] MaxStep = StepW'(2 * SEQ_LENGTH - 2);

    localparam logic [DIR_W-1:0] DirDiag     = DIR_W'(0);
    localparam logic [DIR_W-1:0] DirLeft     = DIR_W'(1);
    localparam logic [DIR_W-1:0] DirReserved = DIR_W'(2);
    localparam logic [DIR_W-1:0] DirTop      = DIR_W'(3);

    typedef enum logic [1:0] {StIdle, StFetch, StStream, StDone} state_e;

    state_e                          state_q, state_d;
    logic [SEQ_LENGTH_W-1:0]         row_q, col_q;
    logic [StepW-1:0]                step_q;
    logic [DATA_PACKET_SIZE-1:0]     packet_q;
    logic                            valid_q;
    logic                            err_q;

    logic [SEQ_LENGTH*CellW-1:0]     mem [SEQ_LENGTH];

    logic                            accept_start;
    logic                            rd_en;
    logic [SEQ_LENGTH_W-1:0]         rd_row, rd_col;
    logic [SEQ_LENGTH*CellW-1:0]     rd_line;
    logic [CellW-1:0]                rd_cell;
    logic [DIR_W-1:0]                rd_dir;
    logic                            rd_zero;
    logic                            row_zero, col_zero;
    logic                            rd_err;
    logic                            rd_last;

    // Matrix is deliberately left out of reset; a write only lands while idle.
    always_ff @(posedge clk) begin
        if (bus.wr_en && (state_q == StIdle)) begin
            mem[bus.wr_row] <= bus.wr_cells;
        end
    end

    always_comb begin
        rd_row = bus.next_row;
        rd_col = bus.next_col;
        if (state_q == StFetch) begin
            rd_row = row_q;
            rd_col = col_q;
        end
        rd_line  = mem[rd_row];
        rd_cell  = rd_line[CellW*int'(rd_col) +: CellW];
        rd_zero  = rd_cell[DIR_W];
        rd_dir   = rd_cell[DIR_W-1:0];
        row_zero = (rd_row == '0);
        col_zero = (rd_col == '0);
        // Step limit forces termination so a looping feedback path cannot run forever.
        rd_err   = (rd_dir == DirReserved) || (step_q == MaxStep);
        rd_last  = rd_zero || rd_err
                || ((rd_dir == DirDiag) && (row_zero || col_zero))
                || ((rd_dir == DirLeft) && col_zero)
                || ((rd_dir == DirTop)  && row_zero);
    end

    always_comb begin
        state_d      = state_q;
        rd_en        = 1'b0;
        accept_start = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start_of_traceback && bus.en_traceback) begin
                    accept_start = 1'b1;
                    state_d      = StFetch;
                end
            end
            StFetch: begin
                if (bus.en_traceback) begin
                    rd_en   = 1'b1;
                    state_d = StStream;
                end
            end
            StStream: begin
                if (packet_q[DATA_PACKET_SIZE-1]) begin
                    state_d = StDone;
                end else if (bus.en_traceback) begin
                    rd_en = 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            row_q    <= '0;
            col_q    <= '0;
            step_q   <= '0;
            packet_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= rd_en;
            if (accept_start) begin
                row_q  <= bus.max_row;
                col_q  <= bus.max_col;
                step_q <= '0;
                err_q  <= 1'b0;
            end
            if (rd_en) begin
                packet_q <= {rd_last, rd_dir};
                step_q   <= step_q + StepW'(1);
                if (rd_err) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.data_packet  = packet_q;
    assign bus.packet_valid = valid_q;
    assign bus.busy         = (state_q != StIdle);
    assign bus.wr_ready     = (state_q == StIdle);
    assign bus.dir_err      = err_q;

endmodule
